// File: rtl/bowling_roll_tx.sv
// rtl/bowling_roll_tx.sv - bowling roll transmitter: frame-rule check, rate-limited N/UPD strobe toward the score keeper.
module bowling_roll_tx #(
    parameter int FRAMES   = 10,
    parameter int MAX_PINS = 10,
    parameter int UPD_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll_valid,
    input  logic [3:0] roll_pins,
    input  logic       Done,
    output logic [3:0] N,
    output logic       UPD,
    output logic       reject,
    output logic [3:0] frame,
    output logic [1:0] roll_idx,
    output logic       game_over
);

    localparam int GW = (UPD_GAP > 1) ? $clog2(UPD_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(UPD_GAP - 1);
    localparam logic [3:0] MAXP = 4'(MAX_PINS);
    localparam logic [3:0] LAST = 4'(FRAMES);

    typedef enum logic [2:0] {
        S_ROLL1  = 3'd0,
        S_ROLL2  = 3'd1,
        S_BONUS1 = 3'd2,
        S_BONUS2 = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pins_q, pins_d;
    logic [3:0]    frame_q, frame_d;
    logic [1:0]    roll_idx_q, roll_idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    n_q, n_d;
    logic          upd_q, reject_q, game_over_q;
    logic          accept, strike, last_frame;

    always_comb begin
        // pins_q never exceeds MAX_PINS, so oversized rolls fail the pins check
        accept     = roll_valid && !Done && (state_q != S_OVER) &&
                     (gap_q == '0) && (roll_pins <= pins_q);
        strike     = (roll_pins == MAXP);
        last_frame = (frame_q == LAST);
        state_d    = state_q;
        pins_d     = pins_q;
        frame_d    = frame_q;
        if (Done) begin
            state_d = S_OVER;
        end else if (accept) begin
            case (state_q)
                S_ROLL1: begin
                    if (strike) begin
                        pins_d = MAXP;
                        if (last_frame) state_d = S_BONUS1;
                        else            frame_d = frame_q + 4'd1;
                    end else begin
                        pins_d  = pins_q - roll_pins;
                        state_d = S_ROLL2;
                    end
                end
                S_ROLL2: begin
                    if (!last_frame) begin
                        frame_d = frame_q + 4'd1;
                        pins_d  = MAXP;
                        state_d = S_ROLL1;
                    end else if (roll_pins == pins_q) begin
                        pins_d  = MAXP;
                        state_d = S_BONUS2;
                    end else begin
                        state_d = S_OVER;
                    end
                end
                S_BONUS1: begin
                    pins_d  = strike ? MAXP : (pins_q - roll_pins);
                    state_d = S_BONUS2;
                end
                S_BONUS2: state_d = S_OVER;
                default:  state_d = S_OVER;
            endcase
        end

        case (state_d)
            S_ROLL1:            roll_idx_d = 2'd0;
            S_ROLL2, S_BONUS1:  roll_idx_d = 2'd1;
            S_BONUS2:           roll_idx_d = 2'd2;
            default:            roll_idx_d = roll_idx_q;
        endcase

        if (accept)            gap_d = GAP_LOAD;
        else if (gap_q != '0)  gap_d = gap_q - 1'b1;
        else                   gap_d = gap_q;

        n_d = accept ? roll_pins : n_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ROLL1;
            pins_q      <= MAXP;
            frame_q     <= 4'd1;
            roll_idx_q  <= 2'd0;
            gap_q       <= '0;
            n_q         <= 4'd0;
            upd_q       <= 1'b0;
            reject_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pins_q      <= pins_d;
            frame_q     <= frame_d;
            roll_idx_q  <= roll_idx_d;
            gap_q       <= gap_d;
            n_q         <= n_d;
            upd_q       <= accept;
            reject_q    <= roll_valid && !accept;
            game_over_q <= game_over_q || (state_d == S_OVER);
        end
    end

    assign N         = n_q;
    assign UPD       = upd_q;
    assign reject    = reject_q;
    assign frame     = frame_q;
    assign roll_idx  = roll_idx_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_bowling_roll_tx.sv
// tb/tb_bowling_roll_tx.sv - directed and randomized checks of bowling_roll_tx against a per-frame ball-list model.
module tb_bowling_roll_tx;

    localparam int FRAMES   = 10;
    localparam int MAX_PINS = 10;
    localparam int UPD_GAP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       roll_valid = 1'b0;
    logic [3:0] roll_pins = 4'd0;
    logic       Done = 1'b0;
    logic [3:0] N;
    logic       UPD;
    logic       reject;
    logic [3:0] frame;
    logic [1:0] roll_idx;
    logic       game_over;

    int checks = 0;
    int failures = 0;
    int upd_seen = 0;
    int mcyc = 0;

    // Reference model: the balls thrown in the current frame, plus game status
    int frame_m, nb_m, over_m, last_acc, n_m;
    int b_m[3];

    bowling_roll_tx #(.FRAMES(FRAMES), .MAX_PINS(MAX_PINS), .UPD_GAP(UPD_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .roll_valid(roll_valid), .roll_pins(roll_pins),
        .Done(Done), .N(N), .UPD(UPD), .reject(reject), .frame(frame),
        .roll_idx(roll_idx), .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (UPD === 1'b1) upd_seen++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mcyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_reset();
        frame_m = 1; nb_m = 0; over_m = 0; last_acc = -1000; n_m = 0;
        b_m[0] = 0; b_m[1] = 0; b_m[2] = 0;
    endtask

    function automatic int max_allowed();
        if (over_m != 0) return -1;
        if (frame_m < FRAMES) return MAX_PINS - ((nb_m == 1) ? b_m[0] : 0);
        case (nb_m)
            0: return MAX_PINS;
            1: return (b_m[0] == MAX_PINS) ? MAX_PINS : MAX_PINS - b_m[0];
            default: return (b_m[0] == MAX_PINS && b_m[1] != MAX_PINS) ? MAX_PINS - b_m[1] : MAX_PINS;
        endcase
    endfunction

    task automatic apply(input int p);
        b_m[nb_m] = p;
        nb_m++;
        if (frame_m < FRAMES) begin
            if ((nb_m == 1 && p == MAX_PINS) || nb_m == 2) begin
                frame_m++;
                nb_m = 0;
            end
        end else if (nb_m == 3 || (nb_m == 2 && b_m[0] + b_m[1] < MAX_PINS)) begin
            over_m = 1;
        end
    endtask

    task automatic req(input int p, input bit d, input string tag);
        int  mx;
        int  e;
        bit  acc;
        mx  = max_allowed();
        e   = mcyc;
        acc = !d && (over_m == 0) && (e - last_acc >= UPD_GAP) && (p <= mx);
        roll_valid = 1'b1;
        roll_pins  = 4'(p);
        Done       = d;
        tick();
        roll_valid = 1'b0;
        Done       = 1'b0;
        if (acc) begin
            last_acc = e;
            n_m = p;
            apply(p);
        end
        if (d) over_m = 1;
        chk($sformatf("%s.upd", tag), 8'(UPD), 8'(acc));
        chk($sformatf("%s.reject", tag), 8'(reject), 8'(!acc));
        chk($sformatf("%s.n", tag), 8'(N), 8'(n_m));
        chk($sformatf("%s.frame", tag), 8'(frame), 8'(frame_m));
        chk($sformatf("%s.game_over", tag), 8'(game_over), 8'(over_m));
        if (over_m == 0) chk($sformatf("%s.roll_idx", tag), 8'(roll_idx), 8'(nb_m));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk($sformatf("%s.rst_n", tag), 8'(N), 8'd0);
        chk($sformatf("%s.rst_upd", tag), 8'(UPD), 8'd0);
        chk($sformatf("%s.rst_reject", tag), 8'(reject), 8'd0);
        chk($sformatf("%s.rst_frame", tag), 8'(frame), 8'd1);
        chk($sformatf("%s.rst_roll_idx", tag), 8'(roll_idx), 8'd0);
        chk($sformatf("%s.rst_game_over", tag), 8'(game_over), 8'd0);
        idle(2);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic play(input int seq[$], input string tag);
        foreach (seq[i]) begin
            req(seq[i], 1'b0, $sformatf("%s[%0d]", tag, i));
            idle(9);
        end
    endtask

    initial begin
        int u0;
        int seq[$];
        int mx, r, p, cnt;

        tick();
        do_reset("init");

        u0 = upd_seen;
        seq = {10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
        play(seq, "perfect");
        chk("perfect.upd_count", 8'(upd_seen - u0), 8'd12);
        chk("perfect.game_over", 8'(game_over), 8'd1);
        req(10, 1'b0, "perfect.extra");

        do_reset("nine");
        u0 = upd_seen;
        seq = {10, 10, 10, 10, 10, 10, 10, 10, 10, 8, 1};
        play(seq, "nine");
        chk("nine.upd_count", 8'(upd_seen - u0), 8'd11);

        do_reset("mixed");
        u0 = upd_seen;
        seq = {8, 2, 10, 7, 1, 10, 10, 10, 0, 10, 3, 7, 5, 5, 8, 1};
        play(seq, "mixed");
        chk("mixed.upd_count", 8'(upd_seen - u0), 8'd16);
        chk("mixed.last_n", 8'(N), 8'd1);

        do_reset("overpin");
        req(7, 1'b0, "overpin.first");
        idle(5);
        req(5, 1'b0, "overpin.five");
        chk("overpin.frame", 8'(frame), 8'd1);
        chk("overpin.roll_idx", 8'(roll_idx), 8'd1);
        idle(2);
        req(3, 1'b0, "overpin.three");
        chk("overpin.n3", 8'(N), 8'd3);
        chk("overpin.frame2", 8'(frame), 8'd2);
        idle(5);
        req(15, 1'b0, "overpin.fifteen");

        do_reset("gap");
        req(2, 1'b0, "gap.a");
        idle(1);
        req(3, 1'b0, "gap.b_early");
        idle(2);
        req(3, 1'b0, "gap.b_late");
        idle(UPD_GAP - 2);
        req(4, 1'b0, "gap.one_short");
        req(4, 1'b0, "gap.exact");

        do_reset("done");
        seq = {10, 10, 10};
        play(seq, "done.pre");
        req(3, 1'b0, "done.f4");
        idle(5);
        req(4, 1'b1, "done.with_req");
        chk("done.game_over", 8'(game_over), 8'd1);
        idle(3);
        req(2, 1'b0, "done.after");

        do_reset("midupd");
        req(5, 1'b0, "midupd.req");
        do_reset("midupd.pulse");
        req(10, 1'b0, "midupd.after");
        tick();
        do_reset("midgap");
        req(6, 1'b0, "midgap.after");

        for (int g = 0; g < 6; g++) begin
            do_reset($sformatf("rnd%0d", g));
            cnt = 0;
            while (over_m == 0 && cnt < 80) begin
                mx = max_allowed();
                r  = $urandom_range(0, 39);
                if (r == 0) begin
                    req($urandom_range(0, mx), 1'b1, $sformatf("rnd%0d.done", g));
                end else if (r < 6) begin
                    p = $urandom_range(mx + 1, 15);
                    req(p, 1'b0, $sformatf("rnd%0d.bad%0d", g, cnt));
                end else begin
                    p = $urandom_range(0, mx);
                    req(p, 1'b0, $sformatf("rnd%0d.r%0d", g, cnt));
                end
                idle($urandom_range(0, 6));
                cnt++;
            end
            req($urandom_range(0, 10), 1'b0, $sformatf("rnd%0d.post", g));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
